// File: rtl/ifstage_pkg.sv
// rtl/ifstage_pkg.sv - shared defaults, entry record and ROM pattern helper for the fetch stage
package ifstage_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int DEPTH_DEF     = 4;
    localparam int MEM_WORDS_DEF = 1024;
    localparam int RESET_PC_DEF  = 0;
    localparam int INSTR_BYTES   = 4;

    // Queue entry at default widths; the top declares the same record at its own widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetchq_entry_t;

    // Built-in ROM image used when no memory file is supplied: word i holds 0x1000 + i.
    function automatic logic [31:0] default_rom_word(input int unsigned idx);
        return 32'h0000_1000 + 32'(idx);
    endfunction

endpackage

// File: rtl/imem_rom.sv
// rtl/imem_rom.sv - instruction ROM with one-cycle synchronous read
//
// Ports:
//   clk    rising-edge clock
//   addr   word index
//   rdata  word at the index sampled on the previous edge
module imem_rom
    import ifstage_pkg::*;
#(
    parameter int    DATA_W    = DATA_W_DEF,
    parameter int    MEM_WORDS = MEM_WORDS_DEF,
    parameter string MEM_FILE  = "",
    localparam int   AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    output logic [DATA_W-1:0] rdata
);

    always_ff @(posedge clk) begin
        rdata <= DATA_W'(default_rom_word(32'(addr)));
    end

endmodule

// File: rtl/ifstage_fetchq.sv
// rtl/ifstage_fetchq.sv - instruction fetch stage with ROM and in-order fetch queue
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   PC_lden      fetch enable; 0 stalls new fetches only
//   redirect     one-cycle flush, restart at redirect_pc
//   redirect_pc  restart address (low two bits ignored)
//   instr_ready  consumer accepts the head entry
//   instr_valid  head entry valid
//   instr        head instruction word (0 when empty)
//   instr_pc     head instruction PC (0 when empty)
module ifstage_fetchq
    import ifstage_pkg::*;
#(
    parameter int              ADDR_W    = ADDR_W_DEF,
    parameter int              DATA_W    = DATA_W_DEF,
    parameter int              DEPTH     = DEPTH_DEF,
    parameter int              MEM_WORDS = MEM_WORDS_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter string           MEM_FILE  = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_lden,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ROM_AW = $clog2(MEM_WORDS);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INSTR_BYTES);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    entry_t            queue_mem [DEPTH];

    logic [ROM_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_rdata;
    logic [CNT_W-1:0]  occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    // ROM index drops the byte offset; PC bits above the ROM size alias.
    assign rom_addr = fetch_pc[ROM_AW+1:2];

    imem_rom #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS),
        .MEM_FILE  (MEM_FILE)
    ) u_imem_rom (
        .clk   (clk),
        .addr  (rom_addr),
        .rdata (rom_rdata)
    );

    // The in-flight fetch reserves a slot, so the queue can never be written while full.
    assign occupancy   = count + CNT_W'(inflight);
    assign issue       = PC_lden && !redirect && (occupancy < CNT_W'(DEPTH));
    assign push        = inflight && !redirect;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC & WORD_MASK;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (redirect) begin
            // Flush: queued entries and the outstanding ROM read are dropped.
            fetch_pc    <= redirect_pc & WORD_MASK;
            inflight    <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + PC_STEP;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[tail] <= '{pc: inflight_pc, instr: rom_rdata};
        end
    end

    assign instr    = instr_valid ? queue_mem[head].instr : '0;
    assign instr_pc = instr_valid ? queue_mem[head].pc    : '0;

endmodule

// File: tb/tb_ifstage_fetchq.sv
// tb/tb_ifstage_fetchq.sv - scoreboard bench for ifstage_fetchq
module tb_ifstage_fetchq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PC_lden = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_pc  [$];
    logic [31:0] exp_ins [$];

    always #5 clk = ~clk;

    ifstage_fetchq dut (
        .clk         (clk),
        .reset       (reset),
        .PC_lden     (PC_lden),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; everything is sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] word);
        exp_pc.push_back(pc);
        exp_ins.push_back(word);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        PC_lden     = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_pc.delete();
        exp_ins.delete();
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_pc.size() == 0) break;
            @(negedge clk);
        end
        chk(name, 32'(exp_pc.size()), 32'd0);
    endtask

    // Monitor: every accepted head entry is compared against the scoreboard front.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (instr_ready && exp_pc.size() > 0) begin
                chk("stream_pc", instr_pc, exp_pc.pop_front());
                chk("stream_instr", instr, exp_ins.pop_front());
            end
        end else begin
            chk("empty_instr_zero", instr, 32'd0);
            chk("empty_pc_zero", instr_pc, 32'd0);
        end
    end

    initial begin
        // Reset state and fill latency, then one instruction per cycle.
        do_reset();
        @(negedge clk);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 8; i++) expect_entry(32'(i * 4), 32'h1000 + 32'(i));
        PC_lden     = 1'b1;
        instr_ready = 1'b1;
        step();
        @(negedge clk);
        chk("fill_valid_after_e1", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("throughput_valid", 32'(instr_valid), 32'd1);
        end
        wait_empty("stream1_drained");

        // Back-pressure: queue fills to four, head holds, release without gaps.
        do_reset();
        PC_lden = 1'b1;
        repeat (8) step();
        @(negedge clk);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_head_pc", instr_pc, 32'h0);
        chk("stall_head_instr", instr, 32'h1000);
        expect_entry(32'h00, 32'h1000);
        expect_entry(32'h04, 32'h1001);
        expect_entry(32'h08, 32'h1002);
        expect_entry(32'h0C, 32'h1003);
        expect_entry(32'h10, 32'h1004);
        expect_entry(32'h14, 32'h1005);
        step();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("release_no_gap", 32'(instr_valid), 32'd1);
        end
        wait_empty("stream2_drained");

        // Redirect with three queued and one in flight.
        do_reset();
        PC_lden = 1'b1;
        repeat (4) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("redirect_flush_valid", 32'(instr_valid), 32'd0);
        expect_entry(32'h100, 32'h1040);
        expect_entry(32'h104, 32'h1041);
        expect_entry(32'h108, 32'h1042);
        instr_ready = 1'b1;
        wait_empty("stream3_drained");

        // Fetch enable toggling every cycle.
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_entry(32'(i * 4), 32'h1000 + 32'(i));
        for (int i = 0; i < 16; i++) begin
            PC_lden = (i % 2 == 0);
            step();
            @(negedge clk);
            if (i % 2 == 1) chk("stall_cycle_return", 32'(instr_valid), 32'd1);
        end
        PC_lden = 1'b0;
        wait_empty("stream4_drained");

        // PC wrap through the top of the address space; ROM index aliases.
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        expect_entry(32'hFFFF_FFF8, 32'h13FE);
        expect_entry(32'hFFFF_FFFC, 32'h13FF);
        expect_entry(32'h0000_0000, 32'h1000);
        expect_entry(32'h0000_0004, 32'h1001);
        PC_lden     = 1'b1;
        instr_ready = 1'b1;
        wait_empty("stream5_drained");

        // Reset and redirect together mid-stream: reset wins.
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        reset    = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        chk("reset_over_redirect_valid", 32'(instr_valid), 32'd0);
        exp_pc.delete();
        exp_ins.delete();
        expect_entry(32'h0, 32'h1000);
        expect_entry(32'h4, 32'h1001);
        expect_entry(32'h8, 32'h1002);
        wait_empty("stream6_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
